// File: rtl/layers_sched_if.sv
// Command, config-bus, image-gate, result-monitor and status signals around layers_sched.
// master is the scheduler side, slave is the control/layers side.
interface layers_sched_if #(
    parameter int CFG_DWIDTH = 32,
    parameter int CFG_AWIDTH = 5,
    parameter int CNT_WIDTH  = 16
);
    logic [32+2*CNT_WIDTH-1:0] cmd_data;
    logic                      cmd_val;
    logic                      cmd_rdy;
    logic [CFG_DWIDTH-1:0]     cfg_data;
    logic [CFG_AWIDTH-1:0]     cfg_addr;
    logic                      cfg_valid;
    logic                      up_image_last;
    logic                      up_image_val;
    logic                      up_image_rdy;
    logic                      image_val;
    logic                      image_rdy;
    logic                      result_val;
    logic                      result_rdy;
    logic                      busy;
    logic                      done;
    logic                      err;

    modport master (
        input  cmd_data, cmd_val, up_image_last, up_image_val, image_rdy, result_val, result_rdy,
        output cmd_rdy, cfg_data, cfg_addr, cfg_valid, up_image_rdy, image_val, busy, done, err
    );

    modport slave (
        output cmd_data, cmd_val, up_image_last, up_image_val, image_rdy, result_val, result_rdy,
        input  cmd_rdy, cfg_data, cfg_addr, cfg_valid, up_image_rdy, image_val, busy, done, err
    );
endinterface

// File: rtl/layers_sched.sv
// Layer sequencer: one cfg write, settle, gate grp_nb image groups, count res_nb results, then done/err.
// Cfg strobe one cycle after cmd accept; image gate is combinational in RUN only, blocked elsewhere.
module layers_sched #(
    parameter int                    CFG_DWIDTH = 32,
    parameter int                    CFG_AWIDTH = 5,
    parameter logic [CFG_AWIDTH-1:0] CFG_ADDR   = 5'd4,
    parameter int                    CNT_WIDTH  = 16,
    parameter int                    SETTLE_CYC = 2,
    parameter int                    TIMEOUT    = 1024
) (
    input  logic          clk,
    input  logic          rst,
    layers_sched_if.master io
);
    typedef enum logic [2:0] {S_IDLE, S_CFG, S_SETTLE, S_RUN, S_DRAIN, S_DONE} state_t;

    localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    state_t               state, state_nx;
    logic [CNT_WIDTH-1:0] res_nb, grp_nb, res_cnt, grp_cnt, res_cnt_nx, grp_cnt_nx;
    logic [SW-1:0]        settle_cnt;
    logic [TW-1:0]        to_cnt;
    logic                 cmd_hs, last_hs, res_hs, active, timed_out;

    assign cmd_hs  = (state == S_IDLE) & io.cmd_val & io.cmd_rdy;
    assign last_hs = (state == S_RUN) & io.up_image_val & io.image_rdy & io.up_image_last;
    assign active  = (state == S_CFG) | (state == S_SETTLE) | (state == S_RUN) | (state == S_DRAIN);
    assign res_hs  = active & io.result_val & io.result_rdy;

    // Results beyond the commanded count are dropped: the counter parks at res_nb.
    assign res_cnt_nx = (res_hs && res_cnt != res_nb) ? res_cnt + CNT_WIDTH'(1) : res_cnt;
    assign grp_cnt_nx = last_hs ? grp_cnt + CNT_WIDTH'(1) : grp_cnt;

    assign io.image_val    = (state == S_RUN) & io.up_image_val;
    assign io.up_image_rdy = (state == S_RUN) & io.image_rdy;

    always_comb begin
        state_nx  = state;
        timed_out = 1'b0;
        case (state)
            S_IDLE:   if (cmd_hs) state_nx = S_CFG;
            S_CFG:    state_nx = S_SETTLE;
            S_SETTLE: if (settle_cnt == SW'(SETTLE_CYC - 1))
                          state_nx = (grp_nb == '0) ? S_DRAIN : S_RUN;
            S_RUN:    if (last_hs && grp_cnt_nx == grp_nb) state_nx = S_DRAIN;
            S_DRAIN: begin
                // Counting the in-flight handshake lets done follow the final result by one cycle.
                if (res_cnt_nx == res_nb) begin
                    state_nx = S_DONE;
                end else if (!res_hs && to_cnt == TW'(TIMEOUT - 1)) begin
                    state_nx  = S_DONE;
                    timed_out = 1'b1;
                end
            end
            S_DONE:   state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            res_nb     <= '0;
            grp_nb     <= '0;
            res_cnt    <= '0;
            grp_cnt    <= '0;
            settle_cnt <= '0;
            to_cnt     <= '0;
        end else begin
            state      <= state_nx;
            settle_cnt <= (state == S_SETTLE) ? settle_cnt + SW'(1) : '0;
            to_cnt     <= (state == S_DRAIN && !res_hs) ? to_cnt + TW'(1) : '0;
            if (cmd_hs) begin
                res_nb  <= io.cmd_data[32+CNT_WIDTH +: CNT_WIDTH];
                grp_nb  <= io.cmd_data[32 +: CNT_WIDTH];
                res_cnt <= '0;
                grp_cnt <= '0;
            end else begin
                res_cnt <= res_cnt_nx;
                grp_cnt <= grp_cnt_nx;
            end
        end
    end

    // Status and cfg outputs are flops decoded from the next state so they line up with it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            io.cmd_rdy   <= 1'b0;
            io.busy      <= 1'b0;
            io.cfg_valid <= 1'b0;
            io.cfg_addr  <= '0;
            io.cfg_data  <= '0;
            io.done      <= 1'b0;
            io.err       <= 1'b0;
        end else begin
            io.cmd_rdy   <= (state_nx == S_IDLE);
            io.busy      <= (state_nx != S_IDLE);
            io.cfg_valid <= (state_nx == S_CFG);
            io.cfg_addr  <= (state_nx == S_CFG) ? CFG_ADDR : '0;
            io.cfg_data  <= (state_nx == S_CFG) ? CFG_DWIDTH'(io.cmd_data[31:0]) : '0;
            io.done      <= (state_nx == S_DONE);
            io.err       <= timed_out;
        end
    end
endmodule

// File: tb/tb_layers_sched.sv
// Directed bench for layers_sched: stimulus queues expected cfg writes and done/err pulses,
// a negedge monitor pops and compares them whenever the DUT strobes.
module tb_layers_sched;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    layers_sched_if #(.CFG_DWIDTH(32), .CFG_AWIDTH(5), .CNT_WIDTH(16)) b ();

    layers_sched #(
        .CFG_DWIDTH(32), .CFG_AWIDTH(5), .CFG_ADDR(5'd4),
        .CNT_WIDTH(16), .SETTLE_CYC(2), .TIMEOUT(8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .io  (b)
    );

    typedef struct { int cyc; logic [31:0] data; } cfg_exp_t;
    typedef struct { int cyc; logic err; } done_exp_t;
    cfg_exp_t  cfg_q[$];
    done_exp_t done_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        cfg_exp_t  ce;
        done_exp_t de;
        if (b.cfg_valid) begin
            if (cfg_q.size() == 0) chk("cfg_unexpected", b.cfg_valid, 1'b0);
            else begin
                ce = cfg_q.pop_front();
                chk("cfg_cycle", cyc, ce.cyc);
                chk("cfg_data", b.cfg_data, ce.data);
                chk("cfg_addr", b.cfg_addr, 5'd4);
            end
        end
        if (b.done) begin
            if (done_q.size() == 0) chk("done_unexpected", b.done, 1'b0);
            else begin
                de = done_q.pop_front();
                chk("done_cycle", cyc, de.cyc);
                chk("done_err", b.err, de.err);
            end
        end
        if (b.err && !b.done) chk("err_alone", b.err, 1'b0);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic [15:0] res, input logic [15:0] grp, input logic [31:0] word,
                            input logic [31:0] exp_cfg, output int e);
        int n = 0;
        b.cmd_data = {res, grp, word};
        b.cmd_val  = 1'b1;
        while (!b.cmd_rdy && n < 40) begin
            tick();
            n++;
        end
        chk("cmd_accept", b.cmd_rdy, 1'b1);
        tick();
        e = cyc;
        b.cmd_val = 1'b0;
        cfg_q.push_back('{e, exp_cfg});
    endtask

    task automatic res_pulse(output int e);
        b.result_val = 1'b1;
        b.result_rdy = 1'b1;
        tick();
        e = cyc;
        b.result_val = 1'b0;
    endtask

    // Entered with cyc at the command edge. Groups are two beats, last on the second.
    task automatic stream(input int ngrp, input int res_nb, input bit toggle,
                          input int ra, input int rb, output int last_edge);
        int n0, grp, beat, rcount, post;
        bit run;
        n0 = cyc; grp = 0; beat = 0; rcount = 0; post = 0; last_edge = -1;
        if (ngrp == 0 && res_nb == 0) done_q.push_back('{n0 + 4, 1'b0});
        b.up_image_val = 1'b1;
        for (int i = 0; i < 80 && post < 2; i++) begin
            run = (ngrp > 0) && (grp < ngrp) && (cyc >= n0 + 3);
            b.image_rdy     = toggle ? cyc[0] : 1'b1;
            b.up_image_last = beat[0];
            b.result_val    = run && (beat == ra || beat == rb);
            b.result_rdy    = 1'b1;
            #1;
            chk("image_val", b.image_val, run);
            chk("up_image_rdy", b.up_image_rdy, run && b.image_rdy);
            if (!run && ((ngrp == 0) ? (cyc >= n0 + 3) : (grp == ngrp))) post++;
            tick();
            if (b.result_val) rcount++;
            if (run && b.image_rdy) begin
                beat++;
                if (b.up_image_last) begin
                    grp++;
                    if (grp == ngrp) begin
                        last_edge = cyc;
                        if (rcount >= res_nb) done_q.push_back('{cyc + 1, 1'b0});
                    end
                end
            end
        end
        b.up_image_val  = 1'b0;
        b.up_image_last = 1'b0;
        b.result_val    = 1'b0;
        b.image_rdy     = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int n, m, e;
        b.cmd_data = '0; b.cmd_val = 1'b0; b.up_image_last = 1'b0; b.up_image_val = 1'b1;
        b.image_rdy = 1'b1; b.result_val = 1'b0; b.result_rdy = 1'b0;
        repeat (3) tick();
        chk("rst_cmd_rdy", b.cmd_rdy, 1'b0);
        chk("rst_busy", b.busy, 1'b0);
        chk("rst_cfg_valid", b.cfg_valid, 1'b0);
        chk("rst_cfg_data", b.cfg_data, 32'h0);
        chk("rst_image_val", b.image_val, 1'b0);
        chk("rst_up_image_rdy", b.up_image_rdy, 1'b0);
        chk("rst_done", b.done, 1'b0);
        chk("rst_err", b.err, 1'b0);
        b.up_image_val = 1'b0; b.image_rdy = 1'b0;
        rst = 1'b1;
        #1;
        chk("rdy_before_edge", b.cmd_rdy, 1'b0);
        tick();
        chk("rdy_after_release", b.cmd_rdy, 1'b1);

        // Basic layer
        send_cmd(16'd2, 16'd2, {8'd0, 8'd1, 8'd12, 8'd23}, 32'h00010C17, n);
        chk("busy_in_cfg", b.busy, 1'b1);
        chk("cmd_rdy_in_cfg", b.cmd_rdy, 1'b0);
        stream(2, 2, 1'b0, -1, -1, m);
        res_pulse(e);
        res_pulse(e);
        done_q.push_back('{e, 1'b0});
        chk("cmd_rdy_during_done", b.cmd_rdy, 1'b0);
        tick();
        chk("cmd_rdy_after_done", b.cmd_rdy, 1'b1);
        chk("busy_after_done", b.busy, 1'b0);

        // Back-pressure
        send_cmd(16'd1, 16'd2, {8'h80, 8'h02, 8'h03, 8'h04}, 32'h80020304, n);
        stream(2, 1, 1'b1, -1, -1, m);
        res_pulse(e);
        done_q.push_back('{e, 1'b0});
        tick();
        chk("cmd_rdy_bp", b.cmd_rdy, 1'b1);

        // Early results, second one on the last-group edge
        send_cmd(16'd2, 16'd2, {8'h00, 8'h00, 8'h00, 8'h01}, 32'h00000001, n);
        stream(2, 2, 1'b0, 1, 3, m);
        chk("cmd_rdy_early", b.cmd_rdy, 1'b1);

        // Timeout: one of three results, then 8 silent DRAIN cycles
        send_cmd(16'd3, 16'd1, {8'hFF, 8'h00, 8'h10, 8'h20}, 32'hFF001020, n);
        stream(1, 3, 1'b0, -1, -1, m);
        res_pulse(e);
        done_q.push_back('{e + 8, 1'b1});
        repeat (9) tick();
        chk("cmd_rdy_timeout", b.cmd_rdy, 1'b1);

        // Zero groups and zero results
        send_cmd(16'd0, 16'd0, {8'h01, 8'h02, 8'h03, 8'h04}, 32'h01020304, n);
        stream(0, 0, 1'b0, -1, -1, m);
        chk("cmd_rdy_zero_both", b.cmd_rdy, 1'b1);
        send_cmd(16'd0, 16'd1, {8'h0A, 8'h0B, 8'h0C, 8'h0D}, 32'h0A0B0C0D, n);
        stream(1, 0, 1'b0, -1, -1, m);
        chk("cmd_rdy_zero_res", b.cmd_rdy, 1'b1);

        // Reset after one of three groups
        send_cmd(16'd1, 16'd3, {8'h00, 8'h00, 8'h00, 8'h05}, 32'h00000005, n);
        b.up_image_val = 1'b1; b.image_rdy = 1'b1; b.up_image_last = 1'b0;
        repeat (3) tick();
        chk("mid_run_rdy", b.up_image_rdy, 1'b1);
        tick();
        b.up_image_last = 1'b1;
        tick();
        b.up_image_last = 1'b0;
        rst = 1'b0;
        #1;
        chk("mid_rst_cmd_rdy", b.cmd_rdy, 1'b0);
        chk("mid_rst_busy", b.busy, 1'b0);
        chk("mid_rst_cfg_valid", b.cfg_valid, 1'b0);
        chk("mid_rst_image_val", b.image_val, 1'b0);
        chk("mid_rst_up_image_rdy", b.up_image_rdy, 1'b0);
        chk("mid_rst_done", b.done, 1'b0);
        chk("mid_rst_err", b.err, 1'b0);
        b.up_image_val = 1'b0; b.image_rdy = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
        tick();
        chk("rdy_after_mid_rst", b.cmd_rdy, 1'b1);
        send_cmd(16'd1, 16'd1, {8'h11, 8'h22, 8'h33, 8'h44}, 32'h11223344, n);
        stream(1, 1, 1'b0, -1, -1, m);
        res_pulse(e);
        done_q.push_back('{e, 1'b0});
        repeat (3) tick();
        chk("cmd_rdy_final", b.cmd_rdy, 1'b1);

        chk("cfg_pending", cfg_q.size(), 0);
        chk("done_pending", done_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
